echo_collect: RTL and testbench
===============================

Name: echo_collect

Overview:
- Upstream neighbour of the multi-echo serializer.
- Opens a measurement window on each laser fire and accepts individual echo results (distance in mm, pulse width) from the TDC/threshold front end.
- Filters the echoes and stores up to MAX_ECHO of them.
- On window close, emits one packed 5-echo frame (80-bit distance bus, 40-bit pulse bus) with a one-cycle valid_m, which the serializer consumes.

Parameters:
- MAX_ECHO, 5, echo slots per frame (fixed to match 80/40-bit buses).
- MIN_PLS, 2, echoes with pulse width below this are discarded.
- WIN_TIMEOUT, 2000, cycles after fire before the window force-closes.
- MIN_GAP, 100, guard cycles after valid_m before the next fire is accepted (serializer needs ≥81).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- fire  in  1  one-cycle laser-fire pulse; opens a window
- win_end  in  1  one-cycle end-of-window pulse
- echo_valid  in  1  one-cycle strobe; echo_distance and echo_pluse valid
- echo_distance  in  16  echo distance, mm; 0 is reserved (no echo)
- echo_pluse  in  8  echo pulse width, ns*2
- mult_distance  out  80  slot0 in [79:64] … slot4 in [15:0]
- mult_pluse  out  40  slot0 in [39:32] … slot4 in [7:0]
- valid_m  out  1  one-cycle frame strobe
- echo_cnt  out  3  number of echoes stored in the emitted frame (0–5)
- overflow  out  1  frame had more than MAX_ECHO accepted echoes
- fire_drop  out  1  one-cycle pulse: a fire was ignored

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
- Reset values: all outputs 0, all slots 0, state IDLE. Reset mid-window discards the partial frame; no valid_m is produced for it.

State machine:
- IDLE: fire → COLLECT. Slots, count, overflow flag and timeout counter are cleared on the same edge.
- COLLECT: timeout counter increments each cycle. Leave on win_end, or when the counter reaches WIN_TIMEOUT-1. Next state is EMIT.
- EMIT: one cycle.
  - Register slots onto mult_distance/mult_pluse, plus echo_cnt and overflow.
  - Assert valid_m for this single cycle.
  - Next state is GAP.
- GAP: counts MIN_GAP cycles, then → IDLE.

Latency and hold:
- valid_m rises 2 edges after the win_end cycle (COLLECT→EMIT edge, then the output register edge).
- Output buses change only on the valid_m edge and are held stable until the next frame.

Echo acceptance (COLLECT only):
- An echo is accepted when echo_valid=1, echo_distance≠0 and echo_pluse≥MIN_PLS.
- The k-th accepted echo goes to slot k (arrival order, slot0 first).
- Unused slots remain 0, so the serializer sees distance 0 for empty slots.

Boundary conditions:
- 6th and later accepted echoes are dropped and set the overflow flag; echo_cnt saturates at 5.
- echo_valid on the same cycle as win_end or timeout: the echo is included.
- echo_valid on the fire cycle (IDLE): the echo is discarded.
- echo_valid in EMIT, GAP or IDLE: ignored.
- fire during COLLECT, EMIT or GAP: ignored, and fire_drop pulses for one cycle.
- win_end outside COLLECT: ignored.
- Zero accepted echoes: a frame is still emitted with all-zero buses and echo_cnt=0. The serializer then reports no-return.

Optional Feature:
- Macro: ECHO_STRONGEST_EN.
- Defined:
  - Slots are kept ordered by echo_pluse, descending; equal widths keep arrival order.
  - Each accepted echo is inserted in one cycle by shifting weaker slots down.
  - When all 5 slots are full, a new echo weaker than or equal to slot4 is dropped; otherwise slot4 is evicted.
  - overflow is set in both cases.
- Undefined: arrival-order slots as described in Behaviour; no comparators are synthesized.

Decomposition:
- Package scanner_echo_pkg:
  - DIST_W=16, PLS_W=8, MAX_ECHO=5
  - state encoding (IDLE, COLLECT, EMIT, GAP)
  - slot struct {distance, pluse}
  - reserved no-echo distance constant 0
- Sub-module echo_slot_insert: 5-slot register array with append (default) or sorted-insert (ECHO_STRONGEST_EN) logic, plus count and overflow.
- The top level holds the FSM, timers and output registers.

Test Plan:
- Three echoes in one window (d/p = 1200/10, 3400/6, 9000/20), then win_end:
  - One valid_m, 2 edges after win_end.
  - mult_distance = 04B0_0D48_2328_0000_0000; mult_pluse = 0A_06_14_00_00.
  - echo_cnt=3, overflow=0.
- fire with no echo and no win_end:
  - valid_m fires WIN_TIMEOUT+1 cycles after fire.
  - Buses all 0, echo_cnt=0.
- Seven valid echoes (distances 100..700, pulse 5):
  - Slots hold 100..500 (hex 0064_00C8_012C_0190_01F4).
  - echo_cnt=5, overflow=1.
- Filtering: echoes (500,1), (0,9), (800,2):
  - Only 800/2 is stored, in slot0; echo_cnt=1.
- Second fire 10 cycles after valid_m:
  - fire_drop pulses; no window opens.
  - A fire at MIN_GAP+1 cycles after valid_m is accepted.
- ECHO_STRONGEST_EN, pulses 4, 9, 4, 12 at distances 10, 20, 30, 40:
  - Slot order by distance is 40, 20, 10, 30.
  - Reset asserted mid-window: no valid_m, all outputs 0.

Source files
------------

// File: rtl/scanner_echo_pkg.sv
// Shared types and constants for the echo collector and its slot store.
package scanner_echo_pkg;
  localparam int DIST_W      = 16;
  localparam int PLS_W       = 8;
  localparam int MAX_ECHO    = 5;
  localparam int CNT_W       = 3;
  localparam int MIN_PLS     = 2;
  localparam int WIN_TIMEOUT = 2000;
  localparam int MIN_GAP     = 100;
  localparam int TMR_W       = 11;

  localparam logic [DIST_W-1:0] NO_ECHO_DIST = '0;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, GAP} state_e;

  typedef struct packed {
    logic [DIST_W-1:0] distance;
    logic [PLS_W-1:0]  pluse;
  } slot_t;
endpackage

// File: rtl/echo_slot_insert.sv
// Five-slot echo store: arrival-order append, or pulse-sorted insert when
// ECHO_STRONGEST_EN is defined. Also tracks stored count and overflow.
module echo_slot_insert
  import scanner_echo_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DIST_W-1:0]          in_distance,
  input  logic [PLS_W-1:0]           in_pluse,
  output logic [MAX_ECHO*DIST_W-1:0] dist_flat,
  output logic [MAX_ECHO*PLS_W-1:0]  pls_flat,
  output logic [CNT_W-1:0]           count,
  output logic                       overflow
);
  slot_t [MAX_ECHO-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  slot_t                in_slot;
  logic                 full;

  assign in_slot = '{distance: in_distance, pluse: in_pluse};
  assign full    = (count_q == CNT_W'(MAX_ECHO));

`ifdef ECHO_STRONGEST_EN
  logic [CNT_W-1:0] ins_pos;
  logic             found;

  // First stored slot strictly weaker than the new echo; equal widths stay ahead.
  always_comb begin
    ins_pos = count_q;
    found   = 1'b0;
    for (int i = 0; i < MAX_ECHO; i++) begin
      if (!found && (CNT_W'(i) < count_q) && (in_pluse > slots_q[i].pluse)) begin
        ins_pos = CNT_W'(i);
        found   = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      slots_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (push) begin
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
`ifdef ECHO_STRONGEST_EN
      // ins_pos == MAX_ECHO means full and not stronger than slot4: drop.
      if (ins_pos == '0) slots_d[0] = in_slot;
      for (int i = 1; i < MAX_ECHO; i++) begin
        if (CNT_W'(i) == ins_pos)     slots_d[i] = in_slot;
        else if (CNT_W'(i) > ins_pos) slots_d[i] = slots_q[i-1];
      end
`else
      for (int i = 0; i < MAX_ECHO; i++) begin
        if (!full && (CNT_W'(i) == count_q)) slots_d[i] = in_slot;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Slot0 lands in the most significant field of each bus.
  always_comb begin
    dist_flat = '0;
    pls_flat  = '0;
    for (int i = 0; i < MAX_ECHO; i++) begin
      dist_flat[(MAX_ECHO-1-i)*DIST_W +: DIST_W] = slots_q[i].distance;
      pls_flat[(MAX_ECHO-1-i)*PLS_W +: PLS_W]    = slots_q[i].pluse;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/echo_collect.sv
// Echo collector: per-fire measurement window, echo filtering, framed output.
// Define ECHO_STRONGEST_EN to keep the five strongest echoes instead of the first five.
module echo_collect
  import scanner_echo_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fire,
  input  logic                       win_end,
  input  logic                       echo_valid,
  input  logic [DIST_W-1:0]          echo_distance,
  input  logic [PLS_W-1:0]           echo_pluse,
  output logic [MAX_ECHO*DIST_W-1:0] mult_distance,
  output logic [MAX_ECHO*PLS_W-1:0]  mult_pluse,
  output logic                       valid_m,
  output logic [CNT_W-1:0]           echo_cnt,
  output logic                       overflow,
  output logic                       fire_drop
);
  state_e                    state_q, state_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [MAX_ECHO*DIST_W-1:0] mdist_q, mdist_d;
  logic [MAX_ECHO*PLS_W-1:0]  mpls_q, mpls_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      valid_q, valid_d;
  logic                      drop_q, drop_d;

  logic                      clear, push;
  logic [MAX_ECHO*DIST_W-1:0] slot_dist;
  logic [MAX_ECHO*PLS_W-1:0]  slot_pls;
  logic [CNT_W-1:0]          slot_cnt;
  logic                      slot_ovf;

  assign push = (state_q == COLLECT) && echo_valid &&
                (echo_distance != NO_ECHO_DIST) && (echo_pluse >= PLS_W'(MIN_PLS));

  echo_slot_insert u_slots (
    .clk        (clk),
    .rst_n      (rst),
    .clear      (clear),
    .push       (push),
    .in_distance(echo_distance),
    .in_pluse   (echo_pluse),
    .dist_flat  (slot_dist),
    .pls_flat   (slot_pls),
    .count      (slot_cnt),
    .overflow   (slot_ovf)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    mdist_d = mdist_q;
    mpls_d  = mpls_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    clear   = 1'b0;
    drop_d  = fire && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = COLLECT;
          tmr_d   = '0;
          clear   = 1'b1;
        end
      end
      COLLECT: begin
        tmr_d = tmr_q + 1'b1;
        if (win_end || (tmr_q == TMR_W'(WIN_TIMEOUT - 1))) state_d = EMIT;
      end
      EMIT: begin
        mdist_d = slot_dist;
        mpls_d  = slot_pls;
        cnt_d   = slot_cnt;
        ovf_d   = slot_ovf;
        valid_d = 1'b1;
        tmr_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        // Guard time so the downstream serializer finishes the previous frame.
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TMR_W'(MIN_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      mdist_q <= '0;
      mpls_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      mdist_q <= mdist_d;
      mpls_q  <= mpls_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign mult_distance = mdist_q;
  assign mult_pluse    = mpls_q;
  assign echo_cnt      = cnt_q;
  assign overflow      = ovf_q;
  assign valid_m       = valid_q;
  assign fire_drop     = drop_q;
endmodule

// File: tb/tb_echo_collect.sv
// Randomized bench for echo_collect: driver pushes expected frames / drop
// pulses into queues, a negedge monitor pops and compares.
module tb_echo_collect;
  localparam int WIN_TIMEOUT = 2000;
  localparam int MIN_GAP     = 100;
  localparam int MIN_PLS     = 2;
  localparam int MAX_ECHO    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fire = 1'b0, win_end = 1'b0, echo_valid = 1'b0;
  logic [15:0] echo_distance = '0;
  logic [7:0]  echo_pluse = '0;
  logic [79:0] mult_distance;
  logic [39:0] mult_pluse;
  logic        valid_m, overflow, fire_drop;
  logic [2:0]  echo_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // scoreboard queues
  int          exp_cyc_q[$];
  logic [79:0] exp_dist_q[$];
  logic [39:0] exp_pls_q[$];
  logic [2:0]  exp_cnt_q[$];
  logic        exp_ovf_q[$];
  int          exp_drop_q[$];

  logic [79:0] held_dist = '0;
  logic [39:0] held_pls = '0;
  logic [2:0]  held_cnt = '0;
  logic        held_ovf = 1'b0;

  logic [15:0] stim_d[$];
  logic [7:0]  stim_p[$];
  logic [15:0] acc_d[$];
  logic [7:0]  acc_p[$];

  echo_collect dut (
    .clk          (clk),
    .rst          (rst),
    .fire         (fire),
    .win_end      (win_end),
    .echo_valid   (echo_valid),
    .echo_distance(echo_distance),
    .echo_pluse   (echo_pluse),
    .mult_distance(mult_distance),
    .mult_pluse   (mult_pluse),
    .valid_m      (valid_m),
    .echo_cnt     (echo_cnt),
    .overflow     (overflow),
    .fire_drop    (fire_drop)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // monitor
  int          m_cyc;
  logic [79:0] m_dist;
  logic [39:0] m_pls;
  logic [2:0]  m_cnt;
  logic        m_ovf;

  always @(negedge clk) begin
    if (rst) begin
      if (valid_m) begin
        if (exp_cyc_q.size() == 0) begin
          chk("unexpected_valid_m", 128'(valid_m), 128'(0));
        end else begin
          m_cyc  = exp_cyc_q.pop_front();
          m_dist = exp_dist_q.pop_front();
          m_pls  = exp_pls_q.pop_front();
          m_cnt  = exp_cnt_q.pop_front();
          m_ovf  = exp_ovf_q.pop_front();
          chk("frame_cycle", 128'(cyc), 128'(m_cyc));
          chk("mult_distance", 128'(mult_distance), 128'(m_dist));
          chk("mult_pluse", 128'(mult_pluse), 128'(m_pls));
          chk("echo_cnt", 128'(echo_cnt), 128'(m_cnt));
          chk("overflow", 128'(overflow), 128'(m_ovf));
          held_dist = m_dist;
          held_pls  = m_pls;
          held_cnt  = m_cnt;
          held_ovf  = m_ovf;
        end
      end else begin
        chk("hold", 128'({mult_distance, mult_pluse, echo_cnt, overflow}),
            128'({held_dist, held_pls, held_cnt, held_ovf}));
      end
      if (fire_drop) begin
        if (exp_drop_q.size() == 0) chk("unexpected_fire_drop", 128'(fire_drop), 128'(0));
        else chk("fire_drop_cycle", 128'(cyc), 128'(exp_drop_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fire = 1'b0;
    win_end = 1'b0;
    echo_valid = 1'b0;
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) begin
      tick();
      clear_inputs();
    end
  endtask

  // Reference: accepted echoes in arrival order -> packed frame.
  task automatic push_expected(input int tv);
    logic [79:0] fd;
    logic [39:0] fp;
    int          cnt;
    logic        ovf;
    fd  = '0;
    fp  = '0;
    cnt = 0;
    ovf = (acc_d.size() > MAX_ECHO);
`ifdef ECHO_STRONGEST_EN
    // stable descending order by pulse width, keep the top five
    while (acc_d.size() > 0 && cnt < MAX_ECHO) begin
      int best = 0;
      for (int j = 1; j < acc_d.size(); j++) if (acc_p[j] > acc_p[best]) best = j;
      fd[(4-cnt)*16 +: 16] = acc_d[best];
      fp[(4-cnt)*8 +: 8]   = acc_p[best];
      acc_d.delete(best);
      acc_p.delete(best);
      cnt++;
    end
`else
    for (int j = 0; j < acc_d.size() && j < MAX_ECHO; j++) begin
      fd[(4-j)*16 +: 16] = acc_d[j];
      fp[(4-j)*8 +: 8]   = acc_p[j];
      cnt++;
    end
`endif
    exp_cyc_q.push_back(tv);
    exp_dist_q.push_back(fd);
    exp_pls_q.push_back(fp);
    exp_cnt_q.push_back(3'(cnt));
    exp_ovf_q.push_back(ovf);
  endtask

  // One full fire -> echoes -> close -> gap sequence, driven from stim_d/stim_p.
  task automatic do_window(input bit use_timeout, input bit echo_on_end, input bit stray_fire);
    int t_fire, tv, n;
    bit last;
    n = stim_d.size();
    tv = 0;
    acc_d.delete();
    acc_p.delete();
    tick();
    fire = 1'b1;
    echo_valid = 1'($urandom_range(0, 1));  // echo on the fire cycle is discarded
    echo_distance = 16'd777;
    echo_pluse = 8'd50;
    t_fire = cyc;
    for (int k = 0; k < n; k++) begin
      tick();
      clear_inputs();
      repeat ($urandom_range(0, 2)) begin
        tick();
        clear_inputs();
      end
      last = (k == n - 1) && echo_on_end;
      if (last && use_timeout) idle_until(t_fire + WIN_TIMEOUT);
      echo_valid = 1'b1;
      echo_distance = stim_d[k];
      echo_pluse = stim_p[k];
      if (stray_fire && $urandom_range(0, 3) == 0) begin
        fire = 1'b1;
        exp_drop_q.push_back(cyc + 1);
      end
      if (last && !use_timeout) begin
        win_end = 1'b1;
        tv = cyc + 2;
      end
      if (stim_d[k] != 0 && stim_p[k] >= 8'(MIN_PLS)) begin
        acc_d.push_back(stim_d[k]);
        acc_p.push_back(stim_p[k]);
      end
    end
    tick();
    clear_inputs();
    if (!use_timeout && !(echo_on_end && n > 0)) begin
      win_end = 1'b1;
      tv = cyc + 2;
      tick();
      clear_inputs();
    end
    if (use_timeout) tv = t_fire + WIN_TIMEOUT + 2;
    push_expected(tv);
    // gap: echo and win_end ignored, early fire dropped
    idle_until(tv + 3);
    echo_valid = 1'b1;
    echo_distance = 16'd4321;
    echo_pluse = 8'd40;
    win_end = 1'b1;
    idle_until(tv + 10);
    fire = 1'b1;
    exp_drop_q.push_back(cyc + 1);
    idle_until(tv + MIN_GAP);
    win_end = 1'b1;  // sampled in IDLE: ignored
    tick();
    clear_inputs();
  endtask

  task automatic set_stim(input int n, input int d0, input int dstep, input int p);
    stim_d.delete();
    stim_p.delete();
    for (int i = 0; i < n; i++) begin
      stim_d.push_back(16'(d0 + i * dstep));
      stim_p.push_back(8'(p));
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_dist", 128'(mult_distance), 128'(0));
    chk("rst_pls", 128'(mult_pluse), 128'(0));
    chk("rst_valid", 128'(valid_m), 128'(0));
    chk("rst_cnt", 128'(echo_cnt), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_drop", 128'(fire_drop), 128'(0));
    rst = 1'b1;
    repeat (2) tick();

    // three echoes, win_end
    stim_d = '{16'd1200, 16'd3400, 16'd9000};
    stim_p = '{8'd10, 8'd6, 8'd20};
    do_window(1'b0, 1'b0, 1'b0);
`ifndef ECHO_STRONGEST_EN
    chk("t1_dist_const", 128'(mult_distance), 128'(80'h04B0_0D48_2328_0000_0000));
    chk("t1_pls_const", 128'(mult_pluse), 128'(40'h0A_06_14_00_00));
`endif

    // timeout with no echoes
    set_stim(0, 0, 0, 0);
    do_window(1'b1, 1'b0, 1'b0);

    // seven valid echoes
    set_stim(7, 100, 100, 5);
    do_window(1'b0, 1'b0, 1'b0);
`ifndef ECHO_STRONGEST_EN
    chk("t3_dist_const", 128'(mult_distance), 128'(80'h0064_00C8_012C_0190_01F4));
`endif

    // filtering
    stim_d = '{16'd500, 16'd0, 16'd800};
    stim_p = '{8'd1, 8'd9, 8'd2};
    do_window(1'b0, 1'b0, 1'b0);

    // strongest-ordering pattern
    stim_d = '{16'd10, 16'd20, 16'd30, 16'd40};
    stim_p = '{8'd4, 8'd9, 8'd4, 8'd12};
    do_window(1'b0, 1'b1, 1'b0);
`ifdef ECHO_STRONGEST_EN
    chk("strong_dist_const", 128'(mult_distance), 128'({16'd40, 16'd20, 16'd10, 16'd30, 16'd0}));
`endif

    // randomized windows
    for (int r = 0; r < 15; r++) begin
      int n;
      n = $urandom_range(0, 8);
      stim_d.delete();
      stim_p.delete();
      for (int i = 0; i < n; i++) begin
        stim_d.push_back(($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
        stim_p.push_back(8'($urandom_range(0, 25)));
      end
      do_window(r == 7, 1'($urandom_range(0, 1)), 1'b1);
    end

    // reset mid-window: partial frame discarded
    tick();
    fire = 1'b1;
    tick();
    clear_inputs();
    echo_valid = 1'b1;
    echo_distance = 16'd555;
    echo_pluse = 8'd9;
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("midrst_dist", 128'(mult_distance), 128'(0));
    chk("midrst_pls", 128'(mult_pluse), 128'(0));
    chk("midrst_valid", 128'(valid_m), 128'(0));
    chk("midrst_cnt", 128'(echo_cnt), 128'(0));
    chk("midrst_ovf", 128'(overflow), 128'(0));
    held_dist = '0;
    held_pls = '0;
    held_cnt = '0;
    held_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    idle_until(cyc + WIN_TIMEOUT + 20);

    // recovery window
    set_stim(2, 1000, 500, 7);
    do_window(1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("frames_left", 128'(exp_cyc_q.size()), 128'(0));
    chk("drops_left", 128'(exp_drop_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
